// File: rtl/bcd_disp_scan_pkg.sv
// bcd_disp_scan_pkg: segment codes and digit count shared by the display scanner
package bcd_disp_scan_pkg;
  localparam int NDIG = 5;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF = 7'h7F;
endpackage

// File: rtl/bcd_disp_scan_if.sv
// bcd_disp_scan_if: converter-side inputs and display-pin outputs of the scanner
interface bcd_disp_scan_if;
  logic [19:0] bcd_in;
  logic load;
  logic blank;
  logic [4:0] digit_en;
  logic [6:0] seg;
  logic frame_done;
  modport master(output bcd_in, load, blank, input digit_en, seg, frame_done);
  modport slave(input bcd_in, load, blank, output digit_en, seg, frame_done);
endinterface

// File: rtl/bcd_disp_scan_bcd_to_7seg.sv
// bcd_to_7seg: one BCD nibble to active-low {g..a} segments, dash for 10-15
module bcd_to_7seg
  import bcd_disp_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/bcd_disp_scan.sv
// bcd_disp_scan: scans five BCD digits onto a multiplexed common-anode 7-segment display
module bcd_disp_scan
  import bcd_disp_scan_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input logic clk,
  input logic rst_n,
  bcd_disp_scan_if.slave bus
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [19:0] pending, shown;
  logic pending_valid, tick, boundary, lz;
  logic [3:0] nib;
  logic [6:0] dec;
  assign tick = cnt == CW'(CLK_DIV - 1);
  assign boundary = tick && idx == 3'(NDIG - 1);
  assign nib = 4'(shown >> {idx, 2'b00});
  // a digit is a leading zero when it and every more significant digit are zero
  assign lz = BLANK_LZ && idx != 3'd0 && (shown >> {idx, 2'b00}) == 20'h0;
  bcd_to_7seg u_dec (.bcd(nib), .seg(dec));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      pending <= '0;
      shown <= '0;
      pending_valid <= 1'b0;
      bus.digit_en <= 5'h1F;
      bus.seg <= SEG_OFF;
      bus.frame_done <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= boundary ? 3'd0 : idx + 3'd1;
      // shown only changes at the frame boundary; a load on that very tick bypasses pending
      if (boundary) begin
        shown <= bus.load ? bus.bcd_in : pending_valid ? pending : shown;
        pending_valid <= 1'b0;
      end else if (bus.load) begin
        pending <= bus.bcd_in;
        pending_valid <= 1'b1;
      end
      bus.frame_done <= boundary;
      bus.digit_en <= bus.blank ? 5'h1F : ~(5'b00001 << idx);
      bus.seg <= (bus.blank || lz) ? SEG_OFF : dec;
    end
endmodule
